// File: rtl/ssram_read_dma_if.sv
// Avalon-MM read-side bus between ssram_read_dma (master) and ssram_controller (slave).
// Active-low read strobe, waitrequest stall and a pipelined readdatavalid return path.
interface ssram_read_dma_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read_n;
    logic              avm_write_n;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read_n,
        output avm_write_n,
        output avm_writedata,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read_n,
        input  avm_write_n,
        input  avm_writedata,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/ssram_read_dma.sv
// Command-driven read engine: turns (addr, len) into single-word Avalon reads and streams the
// returned words out through a credit-protected FIFO, since the return path cannot be stalled.
module ssram_read_dma #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter int FIFO_AW = 4
) (
    input  logic                  CLOCK_0deg,
    input  logic                  reset_reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    ssram_read_dma_if.master      avm,
    output logic                  dout_valid,
    output logic [DATA_W-1:0]     dout_data,
    output logic                  dout_last,
    input  logic                  dout_ready
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  popped;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_count;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic              read_n_q;
    logic              done_q;
    logic              err_q;

    logic              cmd_take;
    logic              cmd_noop;
    logic              rd_accept;
    logic              final_accept;
    logic              fifo_empty;
    logic              fifo_full;
    logic              ret_ok;
    logic              ret_bad;
    logic              pop;
    logic              last_word;
    logic              last_pop;
    logic              read_n_next;
    logic [CW-1:0]     out_next;
    logic [CW-1:0]     cnt_next;
    logic [CW:0]       credit_next;

    always_comb begin
        cmd_take     = (state == IDLE) && cmd_valid && (cmd_len != '0);
        cmd_noop     = (state == IDLE) && cmd_valid && (cmd_len == '0);
        rd_accept    = !read_n_q && !avm.avm_waitrequest;
        final_accept = rd_accept && (issued == len_q - LEN_W'(1));
        fifo_empty   = (fifo_count == '0);
        fifo_full    = (fifo_count == CW'(DEPTH));
        // A return with nothing outstanding, or with no room left, is a controller protocol fault.
        ret_ok       = avm.avm_readdatavalid && (outstanding != '0) && !fifo_full;
        ret_bad      = avm.avm_readdatavalid && !ret_ok;
        last_word    = !fifo_empty && (state != IDLE) && (popped == len_q - LEN_W'(1));
        pop          = !fifo_empty && dout_ready;
        last_pop     = pop && last_word;
        out_next     = outstanding + CW'(rd_accept) - CW'(ret_ok);
        cnt_next     = fifo_count + CW'(ret_ok) - CW'(pop);
        credit_next  = {1'b0, out_next} + {1'b0, cnt_next};
    end

    always_ff @(posedge CLOCK_0deg or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_take)     state_next = ISSUE;
            ISSUE:   if (final_accept) state_next = DRAIN;
            DRAIN:   if (last_pop)     state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Request for next cycle: a stalled request is held; otherwise issue only while the words
    // already in flight plus those buffered leave a free FIFO slot after this cycle's traffic.
    always_comb begin
        read_n_next = 1'b1;
        if (state == IDLE) begin
            read_n_next = !cmd_take;
        end else if ((state == ISSUE) && !final_accept) begin
            if (!read_n_q && avm.avm_waitrequest) begin
                read_n_next = 1'b0;
            end else begin
                read_n_next = !(credit_next < (CW+1)'(DEPTH));
            end
        end
    end

    always_comb begin
        cmd_ready         = (state == IDLE);
        busy              = (state != IDLE);
        done              = done_q;
        err               = err_q;
        avm.avm_address   = addr_q;
        avm.avm_read_n    = read_n_q;
        avm.avm_write_n   = 1'b1;
        avm.avm_writedata = '0;
        dout_valid        = !fifo_empty;
        dout_data         = fifo_mem[rd_ptr];
        dout_last         = last_word;
    end

    always_ff @(posedge CLOCK_0deg or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            addr_q      <= '0;
            len_q       <= '0;
            issued      <= '0;
            popped      <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            read_n_q    <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q      <= cmd_noop || last_pop;
            read_n_q    <= read_n_next;
            outstanding <= out_next;
            fifo_count  <= cnt_next;
            if (ret_bad) begin
                err_q <= 1'b1;
            end
            if (cmd_take) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                issued <= '0;
                popped <= '0;
            end else begin
                if (rd_accept) begin
                    addr_q <= addr_q + ADDR_W'(1);
                    issued <= issued + LEN_W'(1);
                end
                if (pop) begin
                    popped <= popped + LEN_W'(1);
                end
            end
            if (ret_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
        end
    end

    // Storage has no reset: only pointer-covered entries are ever presented with dout_valid.
    always_ff @(posedge CLOCK_0deg) begin
        if (ret_ok) begin
            fifo_mem[wr_ptr] <= avm.avm_readdata;
        end
    end
endmodule

// File: tb/tb_ssram_read_dma.sv
// Bench for ssram_read_dma: a 4-cycle-latency controller model backed by an address-hashed
// memory, plus an order-based scoreboard of the expected address/word sequence per command.
module tb_ssram_read_dma;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              busy;
    logic              done;
    logic              err;
    logic              dout_valid;
    logic [DATA_W-1:0] dout_data;
    logic              dout_last;
    logic              dout_ready = 1'b0;

    ssram_read_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm ();

    ssram_read_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_AW(4)) dut (
        .CLOCK_0deg    (clk),
        .reset_reset_n (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .avm           (avm.master),
        .dout_valid    (dout_valid),
        .dout_data     (dout_data),
        .dout_last     (dout_last),
        .dout_ready    (dout_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit tracking = 1'b0;
    logic [ADDR_W-1:0] exp_base = '0;
    int exp_len = 0;
    int issued_cnt = 0;
    int popped_cnt = 0;
    int done_count = 0;
    int done_cyc = 0;
    int cmd_cyc = 0;
    int last_cyc = 0;
    int accept_cyc[$];
    int ready_mode = 1;
    int wait_pct = 0;
    int stall_idx = -1;
    int stall_left = 0;
    bit inject_stray = 1'b0;
    bit prev_stalled = 1'b0;
    logic [31:0] salt;
    bit pv[4];
    logic [DATA_W-1:0] pd[4];

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a, 4'hA} ^ salt;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        int budget;
        budget = 200;
        while (!cmd_ready && budget > 0) begin
            tick(1);
            budget--;
        end
        checkOutput("cmd_ready_wait", budget > 0, 1);
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic finishCommand(input string tag);
        int budget;
        budget = 3000;
        while (done_count == 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        checkOutput({tag, "_done_timeout"}, budget > 0, 1);
        tick(3);
        checkOutput({tag, "_words"}, popped_cnt, exp_len);
        checkOutput({tag, "_reads"}, issued_cnt, exp_len);
        checkOutput({tag, "_done_count"}, done_count, 1);
        checkOutput({tag, "_done_cycle"}, done_cyc, (exp_len == 0) ? cmd_cyc + 1 : last_cyc + 1);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_idle"}, cmd_ready, 1);
    endtask

    // Controller model, stream consumer and scoreboard; acts at negedge for the coming posedge.
    initial begin
        logic [ADDR_W-1:0] ea;
        avm.avm_waitrequest   = 1'b0;
        avm.avm_readdatavalid = 1'b0;
        avm.avm_readdata      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) pv[i] = 1'b0;
                avm.avm_readdatavalid = 1'b0;
                avm.avm_waitrequest   = 1'b0;
                prev_stalled          = 1'b0;
                dout_ready            = 1'b0;
            end else begin
                if (inject_stray) begin
                    avm.avm_readdatavalid = 1'b1;
                    avm.avm_readdata      = 32'hDEAD_BEEF;
                    inject_stray          = 1'b0;
                end else begin
                    avm.avm_readdatavalid = pv[3];
                    avm.avm_readdata      = pd[3];
                end
                for (int i = 3; i > 0; i--) begin
                    pv[i] = pv[i-1];
                    pd[i] = pd[i-1];
                end
                pv[0] = 1'b0;

                if (cmd_valid && cmd_ready) begin
                    exp_base   = cmd_addr;
                    exp_len    = int'(cmd_len);
                    issued_cnt = 0;
                    popped_cnt = 0;
                    done_count = 0;
                    cmd_cyc    = cyc;
                    accept_cyc.delete();
                    tracking   = 1'b1;
                end
                if (done) begin
                    done_count++;
                    done_cyc = cyc;
                end

                if (tracking && !avm.avm_read_n && issued_cnt == stall_idx && stall_left > 0) begin
                    avm.avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm.avm_waitrequest = (wait_pct > 0) && ($urandom_range(0, 99) < wait_pct);
                end

                dout_ready = (ready_mode == 1) || ((ready_mode == 2) && ($urandom_range(0, 3) != 0));

                if (!tracking) begin
                    checkOutput("idle_read_n", avm.avm_read_n, 1);
                    checkOutput("idle_dout_valid", dout_valid, 0);
                    checkOutput("idle_done", done, 0);
                end else begin
                    if (prev_stalled) checkOutput("hold_read_n", avm.avm_read_n, 0);
                    if (!avm.avm_read_n) begin
                        ea = exp_base + ADDR_W'(issued_cnt);
                        checkOutput("avm_address", avm.avm_address, ea);
                        if (!avm.avm_waitrequest) begin
                            checkOutput("read_in_range", issued_cnt < exp_len, 1);
                            pv[0] = 1'b1;
                            pd[0] = mem_word(avm.avm_address);
                            accept_cyc.push_back(cyc);
                            issued_cnt++;
                        end
                    end
                    if (dout_valid && dout_ready) begin
                        checkOutput("extra_word", popped_cnt < exp_len, 1);
                        ea = exp_base + ADDR_W'(popped_cnt);
                        checkOutput("dout_data", dout_data, mem_word(ea));
                        checkOutput("dout_last", dout_last, popped_cnt == exp_len - 1);
                        if (popped_cnt == exp_len - 1) last_cyc = cyc;
                        popped_cnt++;
                    end
                    checkOutput("credit", (issued_cnt - popped_cnt) <= DEPTH, 1);
                end
                prev_stalled = !avm.avm_read_n && avm.avm_waitrequest;
            end
        end
    end

    initial begin
        salt = $urandom;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_read_n", avm.avm_read_n, 1);
        checkOutput("rst_address", avm.avm_address, 0);
        checkOutput("rst_write_n", avm.avm_write_n, 1);
        checkOutput("rst_dout_valid", dout_valid, 0);
        checkOutput("rst_dout_last", dout_last, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Back-to-back issue with no stalls and an always-ready consumer.
        ready_mode = 1;
        wait_pct   = 0;
        applyStimulus(28'h100, 16'd8);
        finishCommand("t1");
        for (int i = 0; i < 8; i++) begin
            checkOutput("t1_read_cycle", (accept_cyc.size() > i) ? accept_cyc[i] : -1, cmd_cyc + 1 + i);
        end

        // Blocked consumer: issue must stop once 16 words are in flight or buffered.
        ready_mode = 0;
        applyStimulus(28'h2000, 16'd40);
        tick(60);
        checkOutput("t2_credit_halt", issued_cnt, DEPTH);
        checkOutput("t2_dout_valid", dout_valid, 1);
        checkOutput("t2_err", err, 0);
        checkOutput("t2_busy", busy, 1);
        ready_mode = 1;
        finishCommand("t2");

        // Three stall cycles on the second read.
        stall_idx  = 1;
        stall_left = 3;
        applyStimulus(28'h300, 16'd6);
        finishCommand("t3");
        checkOutput("t3_stall_used", stall_left, 0);
        stall_idx = -1;

        // Address wrap at the top of the 28-bit space.
        applyStimulus(28'hFFF_FFFE, 16'd4);
        finishCommand("t4");

        // Zero-length command, then a command with cmd_valid held while busy.
        applyStimulus(28'h55, 16'd0);
        finishCommand("t5_noop");
        applyStimulus(28'h400, 16'd20);
        cmd_addr  = 28'h999;
        cmd_len   = 16'd3;
        cmd_valid = 1'b1;
        tick(3);
        cmd_valid = 1'b0;
        finishCommand("t5_busy");
        checkOutput("t5_base_kept", exp_base, 28'h400);

        // Randomized commands with random stalls and consumer backpressure.
        for (int k = 0; k < 6; k++) begin
            ready_mode = 2;
            wait_pct   = 20;
            applyStimulus(28'($urandom), 16'($urandom_range(1, 48)));
            finishCommand("rand");
        end
        wait_pct = 0;

        // Abort mid-command by reset, then a stray return while idle.
        begin
            int budget;
            ready_mode = 1;
            applyStimulus(28'h3000, 16'd20);
            budget = 500;
            while (popped_cnt < 5 && budget > 0) begin
                tick(1);
                budget--;
            end
            checkOutput("t6_progress", budget > 0, 1);
        end
        tracking = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_cmd_ready", cmd_ready, 1);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_done", done, 0);
        checkOutput("t6_read_n", avm.avm_read_n, 1);
        checkOutput("t6_address", avm.avm_address, 0);
        checkOutput("t6_dout_valid", dout_valid, 0);
        checkOutput("t6_dout_last", dout_last, 0);
        tick(3);
        rst_n = 1'b1;
        tick(6);
        checkOutput("t6_err_clear", err, 0);
        inject_stray = 1'b1;
        tick(4);
        checkOutput("t6_err_sticky", err, 1);
        checkOutput("t6_stray_dout_valid", dout_valid, 0);
        checkOutput("t6_stray_cmd_ready", cmd_ready, 1);
        tick(3);
        checkOutput("t6_err_held", err, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
